// File: rtl/mod_counter_pkg.sv
// Shared mode encodings for the up/down counter and its next-state block.
package mod_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // 2'b11 is reserved and behaves exactly like wrap.
  typedef enum logic [1:0] {
    ModeWrap    = 2'b00,
    ModeSat     = 2'b01,
    ModeOneshot = 2'b10,
    ModeWrapAlt = 2'b11
  } mode_e;

  function automatic logic is_wrap(logic [1:0] mode);
    return (mode == MODE_WRAP) || (mode == 2'b11);
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count logic: step, end-of-range handling and one-shot completion.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] limit_i,
  input  logic         up_i,
  input  logic [1:0]   mode_i,
  output logic [N-1:0] q_next_o,
  output logic         wrap_evt_o,
  output logic         done_set_o
);

  logic         term;
  logic [N-1:0] step;
  logic [N-1:0] term_val;
  mode_e        mode;

  assign mode     = mode_e'(mode_i);
  assign term     = up_i ? (q_i >= limit_i) : (q_i == '0);
  assign step     = up_i ? (q_i + 1'b1) : (q_i - 1'b1);
  assign term_val = up_i ? limit_i : '0;

  always_comb begin
    q_next_o   = q_i;
    wrap_evt_o = 1'b0;
    done_set_o = 1'b0;
    if (!term) begin
      q_next_o   = step;
      done_set_o = (mode == ModeOneshot) && (step == term_val);
    end else begin
      case (mode)
        ModeWrap, ModeWrapAlt: begin
          q_next_o   = up_i ? '0 : limit_i;
          wrap_evt_o = 1'b1;
        end
        // Already terminal in one-shot: hold and flag completion.
        ModeOneshot: done_set_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable limit, wrap/saturate/one-shot modes and status flags.
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter logic [N-1:0] LIM_RST = '1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         syn_clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         en,
  input  logic         up,
  input  logic [1:0]   mode,
  input  logic         lim_wr,
  input  logic [N-1:0] lim_d,
  output logic [N-1:0] q,
  output logic [N-1:0] limit,
  output logic         max_tick,
  output logic         min_tick,
  output logic         wrap_pulse,
  output logic         done
);

  logic [N-1:0] q_q, q_d;
  logic [N-1:0] limit_q, limit_d;
  logic         wrap_q, wrap_d;
  logic         done_q, done_d;

  logic [N-1:0] cnt_next;
  logic         wrap_evt;
  logic         done_set;
  logic         hold;

  mod_counter_next #(
    .N (N)
  ) u_next (
    .q_i        (q_q),
    .limit_i    (limit_q),
    .up_i       (up),
    .mode_i     (mode),
    .q_next_o   (cnt_next),
    .wrap_evt_o (wrap_evt),
    .done_set_o (done_set)
  );

  assign hold = (mode == MODE_ONESHOT) && done_q;

  always_comb begin
    q_d     = q_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    limit_d = lim_wr ? lim_d : limit_q;
    if (syn_clr) begin
      q_d    = '0;
      done_d = 1'b0;
    end else if (load) begin
      q_d    = d;
      done_d = 1'b0;
    end else if (en && !hold) begin
      q_d    = cnt_next;
      wrap_d = wrap_evt;
      done_d = done_q | done_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q     <= '0;
      limit_q <= LIM_RST;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      limit_q <= limit_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign q          = q_q;
  assign limit      = limit_q;
  assign max_tick   = (q_q >= limit_q);
  assign min_tick   = (q_q == '0);
  assign wrap_pulse = wrap_q;
  assign done       = done_q;

endmodule
